// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register-file write scheduler.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    INIT,
    RUN
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the pointer and
// wraps around, so the requester just after the last winner gets first pick.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_grant_idx
);

  // Walk all N positions starting at the pointer and take the first active request.
  always_comb begin
    int  cand;
    logic found;
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(i_ptr) + k) % N;
      if (!found && i_req[cand]) begin
        found          = 1'b1;
        o_grant[cand]  = 1'b1;
        o_grant_idx    = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: a 32-entry clear sweep after reset or on
// request, then round-robin sharing among the writeback requesters.
module regfile_write_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Init_Start,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] Req_Register,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  output logic [NUM_REQ-1:0]            Req_Ready,
  output logic [ADDR_WIDTH-1:0]         Write_Register,
  output logic [DATA_WIDTH-1:0]         Write_Data,
  output logic                          Reg_Write,
  output logic                          Init_Done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(regfile_pkg::REG_COUNT - 1);
  localparam logic [PTR_W-1:0]      LAST_REQ   = PTR_W'(NUM_REQ - 1);

  regfile_pkg::sched_state_t r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [PTR_W-1:0]      r_ptr;
  logic [ADDR_WIDTH-1:0] r_writeRegister;
  logic [DATA_WIDTH-1:0] r_writeData;
  logic                  r_regWrite;
  logic                  r_initDone;

  logic [NUM_REQ-1:0]    w_arbReq;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_grantIdx;
  logic [ADDR_WIDTH-1:0] w_grantReg;
  logic [DATA_WIDTH-1:0] w_grantData;

  // Requests are only visible to the arbiter in RUN and never in a re-clear cycle.
  assign w_arbReq = (r_state == regfile_pkg::RUN && !Init_Start) ? Req_Valid : '0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arbiter (
    .i_req       (w_arbReq),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grantIdx)
  );

  assign w_grantReg  = Req_Register[w_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_grantData = Req_Data[w_grantIdx*DATA_WIDTH +: DATA_WIDTH];

  assign Req_Ready      = w_grant;
  assign Write_Register = r_writeRegister;
  assign Write_Data     = r_writeData;
  assign Reg_Write      = r_regWrite;
  assign Init_Done      = r_initDone;

  // Scheduler FSM: clear sweep in INIT, one granted write per cycle in RUN.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state         <= regfile_pkg::INIT;
      r_count         <= '0;
      r_ptr           <= '0;
      r_writeRegister <= '0;
      r_writeData     <= '0;
      r_regWrite      <= 1'b0;
      r_initDone      <= 1'b0;
    end else begin
      case (r_state)
        regfile_pkg::INIT: begin
          r_regWrite      <= 1'b1;
          r_writeRegister <= r_count;
          r_writeData     <= '0;
          r_count         <= r_count + 1'b1;
          if (r_count == LAST_INDEX) begin
            r_state    <= regfile_pkg::RUN;
            r_initDone <= 1'b1;
          end
        end
        regfile_pkg::RUN: begin
          if (Init_Start) begin
            r_state    <= regfile_pkg::INIT;
            r_count    <= '0;
            r_initDone <= 1'b0;
            r_regWrite <= 1'b0;
          end else if (|w_grant) begin
            r_ptr <= (w_grantIdx == LAST_REQ) ? '0 : w_grantIdx + 1'b1;
            if (w_grantReg != '0) begin
              r_regWrite      <= 1'b1;
              r_writeRegister <= w_grantReg;
              r_writeData     <= w_grantData;
            end else begin
              r_regWrite <= 1'b0;
            end
          end else begin
            r_regWrite <= 1'b0;
          end
        end
        default: begin
          r_state <= regfile_pkg::INIT;
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed vector table, multi-cycle
// sequences for sweep/re-clear/reset, and randomized traffic against a model.
module tb_regfile_write_scheduler;

  logic         Clk;
  logic         Reset;
  logic         Init_Start;
  logic [3:0]   Req_Valid;
  logic [19:0]  Req_Register;
  logic [127:0] Req_Data;
  logic [3:0]   Req_Ready;
  logic [4:0]   Write_Register;
  logic [31:0]  Write_Data;
  logic         Reg_Write;
  logic         Init_Done;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Init_Start     (Init_Start),
    .Req_Valid      (Req_Valid),
    .Req_Register   (Req_Register),
    .Req_Data       (Req_Data),
    .Req_Ready      (Req_Ready),
    .Write_Register (Write_Register),
    .Write_Data     (Write_Data),
    .Reg_Write      (Reg_Write),
    .Init_Done      (Init_Done)
  );

  // Free-running clock, 10 time units per period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: sweep position, fairness pointer and expected outputs.
  bit         mInit;
  int         mIdx;
  int         mPtr;
  logic       expRW;
  logic [4:0] expWR;
  logic [31:0] expWD;
  logic       expDone;
  logic [3:0] lastReady;
  int         lastGrant;

  typedef struct {
    logic [3:0]   valid;
    logic [19:0]  regs;
    logic [127:0] data;
    logic [3:0]   expReady;
    logic         expRW;
    logic         chkData;
    logic [4:0]   expWR;
    logic [31:0]  expWD;
  } vec_t;

  vec_t tbl[8];

  bit         pv[4];
  logic [4:0] pr[4];
  logic [31:0] pd[4];

  function automatic int modelGrant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mInit   = 1'b1;
    mIdx    = 0;
    mPtr    = 0;
    expRW   = 1'b0;
    expWR   = '0;
    expWD   = '0;
    expDone = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("reg_write", 32'(Reg_Write), 32'(expRW));
    checkVal("init_done", 32'(Init_Done), 32'(expDone));
    if (expRW) begin
      checkVal("write_register", 32'(Write_Register), 32'(expWR));
      checkVal("write_data", Write_Data, expWD);
    end
  endtask

  // One clock cycle: drive, check the grant, clock, advance model, check outputs.
  task automatic applyStimulus(input logic [3:0] v, input logic [19:0] regs,
                               input logic [127:0] data, input logic init);
    int g;
    logic [3:0] expReady;
    logic [4:0] r;
    Req_Valid    = v;
    Req_Register = regs;
    Req_Data     = data;
    Init_Start   = init;
    #2;
    g = (mInit || init) ? -1 : modelGrant(v, mPtr);
    expReady = (g >= 0) ? 4'(1 << g) : 4'b0000;
    lastReady = Req_Ready;
    lastGrant = g;
    checkVal("req_ready", 32'(Req_Ready), 32'(expReady));
    @(posedge Clk);
    if (mInit) begin
      expRW = 1'b1;
      expWR = 5'(mIdx);
      expWD = '0;
      if (mIdx == 31) begin
        mInit   = 1'b0;
        expDone = 1'b1;
      end
      mIdx = (mIdx + 1) % 32;
    end else if (init) begin
      mInit   = 1'b1;
      mIdx    = 0;
      expDone = 1'b0;
      expRW   = 1'b0;
    end else if (g >= 0) begin
      r = regs[g*5 +: 5];
      if (r != 5'd0) begin
        expRW = 1'b1;
        expWR = r;
        expWD = data[g*32 +: 32];
      end else begin
        expRW = 1'b0;
      end
      mPtr = (g + 1) % 4;
    end else begin
      expRW = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, '0, '0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_reg_write"}, 32'(Reg_Write), 32'd0);
    checkVal({tag, "_write_register"}, 32'(Write_Register), 32'd0);
    checkVal({tag, "_write_data"}, Write_Data, 32'd0);
    checkVal({tag, "_init_done"}, 32'(Init_Done), 32'd0);
    checkVal({tag, "_req_ready"}, 32'(Req_Ready), 32'd0);
  endtask

  // Test sequence: reset, sweep, vector table, re-clear, reset mid-sweep, random.
  initial begin
    tbl[0] = '{4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0},
               4'b0100, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF};
    tbl[1] = '{4'b0000, 20'd0, 128'd0, 4'b0000, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF};
    tbl[2] = '{4'b0010, 20'd0, {32'h0, 32'h0, 32'h1234, 32'h0},
               4'b0010, 1'b0, 1'b0, 5'd0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      tbl[3+i].valid = 4'b1111;
      tbl[3+i].regs  = {5'd4, 5'd3, 5'd2, 5'd1};
      tbl[3+i].data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      tbl[3+i].expRW = 1'b1;
      tbl[3+i].chkData = 1'b1;
    end
    // pointer sits at 2 after the register-0 request, so grants run 2,3,0,1,2
    tbl[3].expReady = 4'b0100; tbl[3].expWR = 5'd3; tbl[3].expWD = 32'hA000_0002;
    tbl[4].expReady = 4'b1000; tbl[4].expWR = 5'd4; tbl[4].expWD = 32'hA000_0003;
    tbl[5].expReady = 4'b0001; tbl[5].expWR = 5'd1; tbl[5].expWD = 32'hA000_0000;
    tbl[6].expReady = 4'b0010; tbl[6].expWR = 5'd2; tbl[6].expWD = 32'hA000_0001;
    tbl[7].expReady = 4'b0100; tbl[7].expWR = 5'd3; tbl[7].expWD = 32'hA000_0002;

    Reset = 1'b1;
    Init_Start = 1'b0;
    Req_Valid = '0;
    Req_Register = '0;
    Req_Data = '0;
    modelReset();
    repeat (3) @(posedge Clk);
    #1;
    checkAllZero("reset");
    @(posedge Clk);
    #2;
    Reset = 1'b0;

    $display("[TB] initial clear sweep");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(4'b0000, '0, '0, 1'b0);
      checkVal("sweep_index", 32'(Write_Register), 32'(i));
    end
    checkVal("sweep_done", 32'(Init_Done), 32'd1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].regs, tbl[i].data, 1'b0);
      checkVal($sformatf("tbl%0d_ready", i), 32'(lastReady), 32'(tbl[i].expReady));
      checkVal($sformatf("tbl%0d_reg_write", i), 32'(Reg_Write), 32'(tbl[i].expRW));
      if (tbl[i].chkData) begin
        checkVal($sformatf("tbl%0d_wr", i), 32'(Write_Register), 32'(tbl[i].expWR));
        checkVal($sformatf("tbl%0d_wd", i), Write_Data, tbl[i].expWD);
      end
    end

    $display("[TB] re-clear while requester 0 waits");
    applyStimulus(4'b0001, {15'd0, 5'd9}, {96'd0, 32'h5555_0000}, 1'b1);
    checkVal("reclear_ready", 32'(lastReady), 32'd0);
    checkVal("reclear_done_low", 32'(Init_Done), 32'd0);
    checkVal("reclear_idle", 32'(Reg_Write), 32'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(4'b0001, {15'd0, 5'd9}, {96'd0, 32'h5555_0000}, 1'b0);
      checkVal("reclear_index", 32'(Write_Register), 32'(i));
    end
    checkVal("reclear_done", 32'(Init_Done), 32'd1);
    applyStimulus(4'b0001, {15'd0, 5'd9}, {96'd0, 32'h5555_0000}, 1'b0);
    checkVal("post_reclear_ready", 32'(lastReady), 32'd1);
    checkVal("post_reclear_wr", 32'(Write_Register), 32'd9);

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(4'b0000, '0, '0, 1'b1);
    idleCycles(16);
    checkVal("pre_reset_index", 32'(Write_Register), 32'd15);
    Reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge Clk);
    #1;
    checkAllZero("held_reset");
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(4'b0000, '0, '0, 1'b0);
      checkVal("resweep_index", 32'(Write_Register), 32'(i));
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0]   v;
      logic [19:0]  regs;
      logic [127:0] data;
      logic         init;
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pr[i] = 5'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
        v[i] = pv[i];
        regs[i*5 +: 5] = pr[i];
        data[i*32 +: 32] = pd[i];
      end
      init = ($urandom_range(0, 59) == 0);
      applyStimulus(v, regs, data, init);
      if (lastGrant >= 0) pv[lastGrant] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Sequences the single write port of the 32 x 32-bit register file. After reset, and on request, it clears all 32 registers with one write per cycle. In normal operation it shares the write port among NUM_REQ writeback requesters with round-robin arbitration and a valid/ready handshake. It sits between the writeback sources (ALU, load unit, etc.) and the register file's Write_Register / Write_Data / Reg_Write inputs.

## Interface
- NUM_REQ, 4, number of writeback requesters (2..8)
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (32 registers)
- Clk  input  1  clock, rising-edge
- Reset  input  1  asynchronous, active-high reset
- Init_Start  input  1  one-cycle request to re-clear the register file
- Req_Valid  input  NUM_REQ  per-requester write request
- Req_Register  input  NUM_REQ*ADDR_WIDTH  target index; requester i uses slice [i*5 +: 5]
- Req_Data  input  NUM_REQ*DATA_WIDTH  write data; requester i uses slice [i*32 +: 32]
- Req_Ready  output  NUM_REQ  one-hot grant; combinational, asserted in the accepting cycle
- Write_Register  output  ADDR_WIDTH  register file write index, registered
- Write_Data  output  DATA_WIDTH  register file write data, registered
- Reg_Write  output  1  register file write enable, registered, one cycle per write
- Init_Done  output  1  high while in RUN, registered

## Operation
- The state machine has two states: INIT (clear sweep) and RUN (arbitration).
- Reset puts the block in INIT. On reset: clear counter = 0, round-robin pointer = 0, Reg_Write = 0, Write_Register = 0, Write_Data = 0, Init_Done = 0.
- INIT:
  - Every cycle issues Reg_Write = 1, Write_Register = counter, Write_Data = 0, then increments the counter.
  - The edge that issues counter = 31 moves the block to RUN and sets Init_Done = 1.
  - Req_Ready stays all-zero.
  - Init_Start is ignored.
- RUN:
  - Grant goes to the first requester with Req_Valid = 1, searching cyclically from the pointer. Req_Ready[g] = 1 in that cycle; all other Req_Ready bits are 0.
  - A transfer occurs when Req_Valid[g] and Req_Ready[g] are both high. On the next edge: Write_Register = Req_Register[g], Write_Data = Req_Data[g], Reg_Write = 1, pointer = (g+1) mod NUM_REQ.
  - A request targeting register 0 is accepted (ready asserted, pointer advances), but Reg_Write stays 0. Register 0 is never written in RUN.
  - If no request is valid, Reg_Write = 0 next cycle. Write_Register and Write_Data hold their last values, and the pointer is unchanged.
- Init_Start in RUN:
  - Takes priority over all requests. No grant is issued that cycle.
  - On the next edge: INIT, counter = 0, Init_Done = 0, Reg_Write = 0.
  - The sweep starts on the following edge.
- Multiple requesters targeting the same register are serialized in grant order; the last write wins. No merging or hazard detection.
- Requesters must hold Req_Valid, Req_Register and Req_Data stable until they see ready.
- Asynchronous Reset mid-sweep or mid-transfer immediately forces the reset values. A pending un-granted request is not lost; it is retried after the next sweep.

## Timing
- Write latency is 1 cycle: handshake at edge N gives Reg_Write = 1 during cycle N+1.
- Throughput is one write per cycle. With all requesters valid, each is served once every NUM_REQ cycles.
- The clear sweep takes exactly 32 cycles:
  - First clear write appears in the cycle after the first Clk edge following Reset deassertion.
  - Init_Done rises together with the write to register 31.
  - First grant is possible in the cycle after that.
- A re-clear costs 33 cycles from Init_Start to Init_Done: 1 idle cycle plus 32 writes.

## Structure
- Package regfile_pkg:
  - REG_COUNT = 32, ADDR_WIDTH = 5, DATA_WIDTH = 32
  - sched_state_t enum {INIT, RUN}
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and the encoded grant index.
  - Purely combinational.
- The FSM, clear counter, pointer and output registers live in regfile_write_scheduler.

## Test plan
- Reset released, no requests -> Reg_Write = 1 for 32 consecutive cycles with Write_Register 0..31 and Write_Data 0. Init_Done rises with index 31. Req_Ready stays 0 throughout.
- After init, requester 2 alone writes reg 7 = 32'hDEADBEEF -> Req_Ready = 4'b0100 that cycle. Next cycle: Write_Register = 7, Write_Data = 32'hDEADBEEF, Reg_Write = 1.
- All 4 requesters held valid with distinct registers -> grants in order 0,1,2,3,0,…. One Reg_Write per cycle, no gaps.
- Requester 1 writes reg 0 = 32'h1234 -> Req_Ready[1] = 1, pointer advances to 2, Reg_Write stays 0.
- Init_Start pulsed in RUN while requester 0 is valid -> no grant that cycle. Init_Done falls next cycle, then a 32-cycle clear sweep runs. Requester 0 is granted in the first cycle after Init_Done rises.
- Reset asserted mid-sweep at index 15 -> outputs go to 0 immediately. After release, a full sweep restarts at index 0.
